// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor: FSM states, coin codes and event helpers.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        C50  = 2'd1,
        C100 = 2'd2,
        C200 = 2'd3
    } coin_t;

    // Event vector bit order: [0]=50, [1]=100, [2]=200.
    function automatic coin_t event_coin(input logic [2:0] ev);
        case (ev)
            3'b001:  return C50;
            3'b010:  return C100;
            3'b100:  return C200;
            default: return NONE;
        endcase
    endfunction

    function automatic logic multi_event(input logic [2:0] ev);
        return (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchronizer, counting debouncer and a
// registered rising-edge event on the debounced level.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       level_q;
    logic [7:0] cnt;

    // Synchronize, debounce and detect the debounced rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= 8'd0;
            rise    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            rise    <= level & ~level_q;
            if (sync2 == level) begin
                cnt <= 8'd0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: three debounced sensor channels feeding a credit FSM that
// emits one credit pulse per accepted coin followed by a forced idle gap.
// Optional feature: define COIN_HOLD_EN to queue one coin arriving while busy.
//
// state | meaning
// IDLE  | waiting for a coin event
// PULSE | credit pulse for the latched coin is on r50/r100/r200
// GAP   | forced idle after a pulse; gap counter runs down to 0
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s50,
    input  logic       s100,
    input  logic       s200,
    input  logic       accept_en,
    output logic       r50,
    output logic       r100,
    output logic       r200,
    output logic       rej,
    output logic [1:0] state
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    logic [2:0] ev;
    state_t     cur, nxt;
    coin_t      coin_q, coin_n;
    logic [3:0] gap_cnt, gap_n;
    coin_t      single;
    logic       any_ev;
    logic       multi;
`ifdef COIN_HOLD_EN
    coin_t      hold_q, hold_n;
`endif

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db50 (
        .clk(clk), .rst(rst), .raw(s50), .rise(ev[0])
    );
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db100 (
        .clk(clk), .rst(rst), .raw(s100), .rise(ev[1])
    );
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db200 (
        .clk(clk), .rst(rst), .raw(s200), .rise(ev[2])
    );

    assign single = event_coin(ev);
    assign multi  = multi_event(ev);
    assign any_ev = |ev;

    assign state = cur;
    assign r50   = (cur == PULSE) && (coin_q == C50);
    assign r100  = (cur == PULSE) && (coin_q == C100);
    assign r200  = (cur == PULSE) && (coin_q == C200);

    // Next-state, latched-coin, gap-counter and reject decisions.
    always_comb begin
        nxt    = cur;
        coin_n = coin_q;
        gap_n  = gap_cnt;
        rej    = 1'b0;
`ifdef COIN_HOLD_EN
        hold_n = hold_q;
`endif

        // Events while busy: queue a lone coin into an empty hold slot, else reject.
        if (cur == PULSE || cur == GAP) begin
`ifdef COIN_HOLD_EN
            if (multi) begin
                rej = 1'b1;
            end else if (any_ev) begin
                if (hold_q == NONE) hold_n = single;
                else                rej    = 1'b1;
            end
`else
            if (any_ev) rej = 1'b1;
`endif
        end

        case (cur)
            IDLE: begin
`ifdef COIN_HOLD_EN
                // A coin captured in the last gap cycle is served before new events.
                if (hold_q != NONE) begin
                    hold_n = NONE;
                    if (any_ev) rej = 1'b1;
                    if (accept_en) begin
                        coin_n = hold_q;
                        nxt    = PULSE;
                    end else begin
                        rej = 1'b1;
                    end
                end else
`endif
                begin
                    if (multi) begin
                        rej = 1'b1;
                    end else if (any_ev) begin
                        if (accept_en) begin
                            coin_n = single;
                            nxt    = PULSE;
                        end else begin
                            rej = 1'b1;
                        end
                    end
                end
            end
            PULSE: begin
                gap_n = GAP_LOAD;
                nxt   = GAP;
            end
            GAP: begin
                gap_n = gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) begin
                    nxt = IDLE;
`ifdef COIN_HOLD_EN
                    if (hold_q != NONE) begin
                        hold_n = NONE;
                        if (accept_en) begin
                            coin_n = hold_q;
                            nxt    = PULSE;
                        end else begin
                            rej = 1'b1;
                        end
                    end
`endif
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // State, latched coin, gap counter and hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            coin_q  <= NONE;
            gap_cnt <= 4'd0;
`ifdef COIN_HOLD_EN
            hold_q  <= NONE;
`endif
        end else begin
            cur     <= nxt;
            coin_q  <= coin_n;
            gap_cnt <= gap_n;
`ifdef COIN_HOLD_EN
            hold_q  <= hold_n;
`endif
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4, GAP_CYCLES=2).
// A sensor raised just after edge t-1 first lands at edge t; its credit pulse is
// visible just after edge t+7 and a reject for it just after edge t+6.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic       s50, s100, s200, accept_en;
    logic       r50, r100, r200, rej;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    coin_acceptor #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .s50(s50), .s100(s100), .s200(s200),
        .accept_en(accept_en), .r50(r50), .r100(r100), .r200(r200),
        .rej(rej), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        s50 = 1'b0; s100 = 1'b0; s200 = 1'b0;
        for (int k = 0; k < 15; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; s50 = 1'b0; s100 = 1'b1; s200 = 1'b0; accept_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if ({r50, r100, r200, rej} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %b want 0000", i, {r50, r100, r200, rej});
            end
            n_cmp++;
            if (state !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_state cycle %0d: got %0d want 0", i, state);
            end
        end
        s100 = 1'b0;
        rst = 1'b0;
        settle();
    endtask

    task automatic test_clean_s100();
        accept_en = 1'b1;
        s100 = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            step();
            n_cmp++;
            if (r100 !== (i == 7)) begin
                n_bad++;
                $display("FAIL clean_r100 edge %0d: got %b want %b", i, r100, (i == 7));
            end
            n_cmp++;
            if ({r50, r200, rej} !== 3'b000) begin
                n_bad++;
                $display("FAIL clean_others edge %0d: got %b want 000", i, {r50, r200, rej});
            end
            if (i == 7 || i == 8 || i == 10) begin
                n_cmp++;
                if (state !== ((i == 7) ? 2'd1 : (i == 8) ? 2'd2 : 2'd0)) begin
                    n_bad++;
                    $display("FAIL clean_state edge %0d: got %0d", i, state);
                end
            end
            if (i == 9) s100 = 1'b0;
        end
        settle();
    endtask

    task automatic test_bounce();
        accept_en = 1'b1;
        s50 = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            step();
            n_cmp++;
            if ({r50, r100, r200, rej} !== 4'b0000) begin
                n_bad++;
                $display("FAIL bounce edge %0d: got %b want 0000", i, {r50, r100, r200, rej});
            end
            if (i == 0) s50 = 1'b0;
            if (i == 1) s50 = 1'b1;
            if (i == 2) s50 = 1'b0;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        accept_en = 1'b1;
        s50 = 1'b1; s200 = 1'b1;
        for (int i = 0; i <= 14; i++) begin
            step();
            n_cmp++;
            if (rej !== (i == 6)) begin
                n_bad++;
                $display("FAIL simul_rej edge %0d: got %b want %b", i, rej, (i == 6));
            end
            n_cmp++;
            if ({r50, r100, r200} !== 3'b000 || state !== 2'd0) begin
                n_bad++;
                $display("FAIL simul_idle edge %0d: got r=%b state=%0d want r=000 state=0", i, {r50, r100, r200}, state);
            end
            if (i == 5) begin s50 = 1'b0; s200 = 1'b0; end
        end
        settle();
    endtask

    task automatic test_accept_en();
        accept_en = 1'b0;
        s200 = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            n_cmp++;
            if (rej !== (i == 6) || r200 !== 1'b0) begin
                n_bad++;
                $display("FAIL accept_off edge %0d: got rej=%b r200=%b want rej=%b r200=0", i, rej, r200, (i == 6));
            end
            if (i == 5) s200 = 1'b0;
        end
        settle();
        accept_en = 1'b1;
        s200 = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            n_cmp++;
            if (r200 !== (i == 7) || rej !== 1'b0) begin
                n_bad++;
                $display("FAIL accept_on edge %0d: got r200=%b rej=%b want r200=%b rej=0", i, r200, rej, (i == 7));
            end
            if (i == 5) s200 = 1'b0;
        end
        settle();
    endtask

    task automatic test_busy_event();
        logic exp_rej, exp_r100;
        accept_en = 1'b1;
        s50 = 1'b1;
        for (int i = 0; i <= 18; i++) begin
            step();
`ifdef COIN_HOLD_EN
            exp_rej  = 1'b0;
            exp_r100 = (i == 10);
`else
            exp_rej  = (i == 8);
            exp_r100 = 1'b0;
`endif
            n_cmp++;
            if (r50 !== (i == 7)) begin
                n_bad++;
                $display("FAIL busy_r50 edge %0d: got %b want %b", i, r50, (i == 7));
            end
            n_cmp++;
            if (rej !== exp_rej) begin
                n_bad++;
                $display("FAIL busy_rej edge %0d: got %b want %b", i, rej, exp_rej);
            end
            n_cmp++;
            if (r100 !== exp_r100 || r200 !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_r100 edge %0d: got r100=%b r200=%b want r100=%b r200=0", i, r100, r200, exp_r100);
            end
            if (i == 1) s100 = 1'b1;
            if (i == 5) s50 = 1'b0;
            if (i == 7) s100 = 1'b0;
        end
        settle();
    endtask

    task automatic test_reset_in_pulse();
        accept_en = 1'b1;
        s50 = 1'b1;
        for (int i = 0; i <= 7; i++) step();
        n_cmp++;
        if (r50 !== 1'b1 || state !== 2'd1) begin
            n_bad++;
            $display("FAIL rstpulse_pre: got r50=%b state=%0d want r50=1 state=1", r50, state);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({r50, r100, r200, rej} !== 4'b0000 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL rstpulse_now: got %b state=%0d want 0000 state=0", {r50, r100, r200, rej}, state);
        end
        s50 = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i <= 15; i++) begin
            step();
            n_cmp++;
            if ({r50, r100, r200, rej} !== 4'b0000) begin
                n_bad++;
                $display("FAIL rstpulse_after edge %0d: got %b want 0000", i, {r50, r100, r200, rej});
            end
        end
    endtask

    initial begin
        rst = 1'b1; s50 = 1'b0; s100 = 1'b0; s200 = 1'b0; accept_en = 1'b0;
        test_reset();
        test_clean_s100();
        test_bounce();
        test_simultaneous();
        test_accept_en();
        test_busy_event();
        test_reset_in_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to change a debounced level (range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced after each output pulse (range 1..15).
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s50, s100, s200  in  1 each  raw, asynchronous, bouncing coin-sensor levels, high while a coin passes.
REQ-006 SHALL have port accept_en  in  1  downstream vending FSM ready to take credit.
REQ-007 SHALL have ports r50, r100, r200  out  1 each  single-cycle credit pulses to the vending FSM.
REQ-008 SHALL have port rej  out  1  single-cycle pulse commanding the coin-return flap.
REQ-009 SHALL have port state  out  2  current FSM state encoding, for debug.

Function
REQ-010 SHALL pass each sensor through a 2-flop synchronizer, then a debouncer that updates its debounced level only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any agreeing cycle.
REQ-011 SHALL raise a one-cycle event for a channel on each rising edge of its debounced level; falling edges produce no event.
REQ-012 SHALL implement FSM states IDLE=0, PULSE=1, GAP=2; encoding 3 is unused and SHALL recover to IDLE.
REQ-013 IDLE: exactly one event with accept_en=1 SHALL latch that coin and go to PULSE.
REQ-014 IDLE: two or more simultaneous events SHALL assert rej for one cycle, discard all of them, and stay in IDLE.
REQ-015 IDLE: any event with accept_en=0 SHALL assert rej for one cycle and stay in IDLE.
REQ-016 PULSE: exactly one of r50/r100/r200, matching the latched coin, SHALL be high for exactly one cycle; the next state SHALL be GAP with the gap counter loaded to GAP_CYCLES.
REQ-017 GAP: the counter SHALL decrement each cycle; on reaching 0, the FSM SHALL return to IDLE (or follow REQ-024).
REQ-018 r outputs SHALL be mutually exclusive in every cycle and SHALL never be high outside PULSE.
REQ-019 Events arriving in PULSE or GAP SHALL be handled per REQ-023/REQ-024; rej SHALL be asserted at most once per cycle regardless of event count.
REQ-020 Latency: a raw sensor held high and clean from edge t SHALL produce its r pulse at edge t+DEBOUNCE_CYCLES+3 when the FSM is IDLE and accept_en=1.

Reset
REQ-021 rst SHALL asynchronously clear synchronizers, debounced levels, counters, latched coin, and hold register, and force IDLE; r50/r100/r200/rej SHALL be 0 and state SHALL be 0 while rst is high.
REQ-022 rst asserted during PULSE SHALL suppress that pulse; no pulse SHALL be emitted after release for a coin seen before reset.

Configuration
REQ-023 Without COIN_HOLD_EN defined, every event during PULSE or GAP SHALL be rejected (rej pulse) and discarded.
REQ-024 With COIN_HOLD_EN defined, a one-deep hold register SHALL capture a single event arriving in PULSE/GAP when empty; simultaneous events or an event arriving with the register full SHALL be rejected; at GAP end a held coin SHALL go directly to PULSE if accept_en=1, else SHALL be rejected and cleared.

Structure
REQ-025 Package coin_pkg SHALL hold the state enum (IDLE/PULSE/GAP) and the coin code enum (NONE, C50, C100, C200, 2 bits).
REQ-026 Sub-module coin_debounce (synchronizer + debouncer + rising-edge detect, one channel) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=2)
REQ-027 Clean s100 high for 10 cycles, accept_en=1 -> single r100 pulse 7 edges after the rise; no other output.
REQ-028 s50 toggling every cycle for 3 cycles, then steady low -> no r pulse and no rej.
REQ-029 s50 and s200 rising on the same cycle -> one rej pulse, no r pulse, state stays 0.
REQ-030 s200 event with accept_en=0 -> rej pulse; repeat with accept_en=1 -> r200 pulse.
REQ-031 s50 event, then s100 event arriving during GAP -> without macro: r50 then rej; with COIN_HOLD_EN: r50, then r100 exactly 3 cycles later.
REQ-032 rst asserted in the PULSE cycle -> r outputs 0 immediately; no pulse after release.
